// File: rtl/wb_rr_arbiter.sv
// ============================================================================
//  Module   : wb_rr_arbiter
//  Brief    : Four-master round-robin Wishbone arbiter onto one shared slave.
//             Optional bus watchdog enabled by macro WB_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   m_cyc_i,
    input  logic [3:0]   m_stb_i,
    input  logic [3:0]   m_we_i,
    input  logic [15:0]  m_sel_i,
    input  logic [127:0] m_adr_i,
    input  logic [127:0] m_dat_i,
    output logic [31:0]  m_dat_o,
    output logic [3:0]   m_ack_o,
    output logic [3:0]   m_err_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    output logic         s_we_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    input  logic [31:0]  s_dat_i,
    input  logic         s_ack_i,
    output logic [3:0]   gnt_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_gnt_idx;
    logic [1:0]  r_last_gnt;
    logic [1:0]  w_pick_idx;
    logic        w_pick_valid;
    logic        w_timeout;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
            $error("wb_rr_arbiter: TIMEOUT_CYCLES must be within 1..255");
        end
    endgenerate

    // Search upward from the master after the last one served.
    always_comb begin
        logic [1:0] w_cand;
        w_pick_valid = 1'b0;
        w_pick_idx   = 2'd0;
        w_cand       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last_gnt + 2'(i);
            if (!w_pick_valid && m_cyc_i[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_tmo_cnt;

    // An ack in the same cycle as the limit wins over the timeout.
    assign w_timeout = (r_state == BUSY) && (r_tmo_cnt == C_TMO_LIMIT) && !s_ack_i;
    assign m_err_o   = w_timeout ? r_gnt : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == IDLE || s_ack_i || w_timeout) begin
            r_tmo_cnt <= 8'd0;
        end else if (s_stb_o) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign m_err_o   = 4'b0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= 4'b0000;
            r_gnt_idx  <= 2'd0;
            r_last_gnt <= 2'd3;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt     <= 4'b0001 << w_pick_idx;
                        r_gnt_idx <= w_pick_idx;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Holding while cyc stays high keeps locked sequences intact.
                    if (!m_cyc_i[r_gnt_idx] || w_timeout) begin
                        r_gnt      <= 4'b0000;
                        r_last_gnt <= r_gnt_idx;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (r_state == BUSY) begin
            s_adr_o = m_adr_i[{r_gnt_idx, 5'd0} +: 32];
            s_dat_o = m_dat_i[{r_gnt_idx, 5'd0} +: 32];
            s_sel_o = m_sel_i[{r_gnt_idx, 2'd0} +: 4];
            s_we_o  = m_we_i[r_gnt_idx];
            s_cyc_o = m_cyc_i[r_gnt_idx] & ~w_timeout;
            s_stb_o = m_stb_i[r_gnt_idx] & ~w_timeout;
        end
    end

    assign m_ack_o = {4{s_ack_i}} & r_gnt & m_stb_i;
    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
//  Module   : tb_wb_rr_arbiter
//  Brief    : Directed and randomized checks of wb_rr_arbiter against a
//             round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   cyc, stb, we;
    logic [3:0]   sel [4];
    logic [31:0]  adr [4];
    logic [31:0]  dat [4];
    logic [31:0]  s_dat_i;
    logic         s_ack_i;

    wire  [127:0] m_adr_i = {adr[3], adr[2], adr[1], adr[0]};
    wire  [127:0] m_dat_i = {dat[3], dat[2], dat[1], dat[0]};
    wire  [15:0]  m_sel_i = {sel[3], sel[2], sel[1], sel[0]};
    wire  [31:0]  m_dat_o, s_adr_o, s_dat_o;
    wire  [3:0]   m_ack_o, m_err_o, s_sel_o, gnt_o;
    wire          s_we_o, s_cyc_o, s_stb_o;

    int tests = 0;
    int fails = 0;

    wb_rr_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc_i (cyc),
        .m_stb_i (stb),
        .m_we_i  (we),
        .m_sel_i (m_sel_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        cyc = 4'b0; stb = 4'b0; we = 4'b0;
        s_ack_i = 1'b0; s_dat_i = 32'd0;
        for (int k = 0; k < 4; k++) begin
            sel[k] = 4'hF; adr[k] = 32'd0; dat[k] = 32'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        s_ack_i = 1'b1;
        stb = 4'hF;
        #3;
        @(negedge clk);
        tests++;
        if (gnt_o !== 4'b0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_bus: gnt=%b cyc=%b stb=%b, want 0000/0/0", gnt_o, s_cyc_o, s_stb_o);
        end
        tests++;
        if (m_ack_o !== 4'b0 || m_err_o !== 4'b0) begin
            fails++;
            $display("FAIL reset_ack_err: ack=%b err=%b, want 0000/0000", m_ack_o, m_err_o);
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        cyc = 4'b0001; stb = 4'b0001; adr[0] = 32'h2000_0000; dat[0] = 32'hCAFE_0001;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0001 || s_adr_o !== 32'h2000_0000 || s_cyc_o !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: gnt=%b adr=%h cyc=%b, want 0001/20000000/1", gnt_o, s_adr_o, s_cyc_o);
        end
        @(negedge clk);
        tests++;
        if (m_ack_o !== 4'b0) begin
            fails++;
            $display("FAIL single_noack: ack=%b, want 0000", m_ack_o);
        end
        @(negedge clk);
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        #1;
        tests++;
        if (m_ack_o !== 4'b0001 || m_dat_o !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_ack: ack=%b dat=%h, want 0001/12345678", m_ack_o, m_dat_o);
        end
        @(negedge clk);
        s_ack_i = 1'b0; cyc = 4'b0; stb = 4'b0;
        #1;
        tests++;
        if (m_ack_o !== 4'b0) begin
            fails++;
            $display("FAIL single_ack_pulse: ack=%b, want 0000", m_ack_o);
        end
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0) begin
            fails++;
            $display("FAIL single_release: gnt=%b, want 0000", gnt_o);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        cyc = 4'hF; stb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (gnt_o !== exp_seq[i]) begin
                fails++;
                $display("FAIL rotation_grant[%0d]: gnt=%b, want %b", i, gnt_o, exp_seq[i]);
            end
            @(negedge clk);
            s_ack_i = 1'b1;
            #1;
            tests++;
            if (m_ack_o !== exp_seq[i]) begin
                fails++;
                $display("FAIL rotation_ack[%0d]: ack=%b, want %b", i, m_ack_o, exp_seq[i]);
            end
            @(negedge clk);
            s_ack_i = 1'b0; cyc = 4'hF & ~exp_seq[i]; stb = cyc;
            @(posedge clk); #1;
            tests++;
            if (gnt_o !== 4'b0) begin
                fails++;
                $display("FAIL rotation_idle[%0d]: gnt=%b, want 0000", i, gnt_o);
            end
            @(negedge clk);
            cyc = 4'hF; stb = 4'hF;
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc = 4'b0100; stb = 4'b0100;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0100) begin
            fails++;
            $display("FAIL b2b_grant: gnt=%b, want 0100", gnt_o);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            cyc = 4'b0101; stb = 4'b0101; s_ack_i = 1'b1;
            #1;
            tests++;
            if (m_ack_o !== 4'b0100) begin
                fails++;
                $display("FAIL b2b_ack[%0d]: ack=%b, want 0100", b, m_ack_o);
            end
            @(posedge clk); #1;
            tests++;
            if (gnt_o !== 4'b0100) begin
                fails++;
                $display("FAIL b2b_hold[%0d]: gnt=%b, want 0100", b, gnt_o);
            end
        end
        @(negedge clk);
        s_ack_i = 1'b0; cyc = 4'b0001; stb = 4'b0001;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0) begin
            fails++;
            $display("FAIL b2b_turnaround: gnt=%b, want 0000", gnt_o);
        end
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_next: gnt=%b, want 0001", gnt_o);
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc = 4'b1000; stb = 4'b1000;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b1000) begin
            fails++;
            $display("FAIL rstmid_grant: gnt=%b, want 1000", gnt_o);
        end
        @(negedge clk);
        #2;
        rst = 1'b1; s_ack_i = 1'b1;
        #1;
        tests++;
        if (gnt_o !== 4'b0 || s_cyc_o !== 1'b0 || m_ack_o !== 4'b0 || m_err_o !== 4'b0) begin
            fails++;
            $display("FAIL rstmid_async: gnt=%b cyc=%b ack=%b err=%b, want all 0", gnt_o, s_cyc_o, m_ack_o, m_err_o);
        end
        @(negedge clk);
        rst = 1'b0; s_ack_i = 1'b0; cyc = 4'b1001; stb = 4'b1001;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0001) begin
            fails++;
            $display("FAIL rstmid_priority: gnt=%b, want 0001", gnt_o);
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        cyc = 4'b0010; stb = 4'b0010;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0010) begin
            fails++;
            $display("FAIL tmo_grant: gnt=%b, want 0010", gnt_o);
        end
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            tests++;
            if (m_err_o !== 4'b0) begin
                fails++;
                $display("FAIL tmo_early[%0d]: err=%b, want 0000", i, m_err_o);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (m_err_o !== 4'b0010 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            fails++;
            $display("FAIL tmo_err: err=%b cyc=%b stb=%b, want 0010/0/0", m_err_o, s_cyc_o, s_stb_o);
        end
        @(negedge clk);
        cyc = 4'b1000; stb = 4'b1000;
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b0 || m_err_o !== 4'b0) begin
            fails++;
            $display("FAIL tmo_clear: gnt=%b err=%b, want 0000/0000", gnt_o, m_err_o);
        end
        @(posedge clk); #1;
        tests++;
        if (gnt_o !== 4'b1000) begin
            fails++;
            $display("FAIL tmo_next: gnt=%b, want 1000", gnt_o);
        end
        @(negedge clk);
        s_ack_i = 1'b1;
        #1;
        tests++;
        if (m_ack_o !== 4'b1000) begin
            fails++;
            $display("FAIL tmo_next_ack: ack=%b, want 1000", m_ack_o);
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
    endtask
`endif

    // Randomized masters and slave; model tracks owner and last-served master.
    task automatic test_random();
        int         mg, ml, starve;
        int         beats [4];
        logic [3:0] drop;
        logic [3:0] exp_ack, exp_gnt;
        logic [31:0] exp_adr, exp_dat;
        logic [3:0] exp_sel;
        logic       exp_we, exp_cyc, exp_stb;
        do_reset();
        mg = -1; ml = 3; starve = 0; drop = 4'b0;
        for (int k = 0; k < 4; k++) beats[k] = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (drop[k]) begin
                    cyc[k] = 1'b0; drop[k] = 1'b0;
                end else if (!cyc[k] && $urandom_range(0, 3) == 0) begin
                    cyc[k] = 1'b1; beats[k] = $urandom_range(1, 4);
                end
                stb[k] = cyc[k] && ($urandom_range(0, 3) != 0);
                we[k]  = 1'($urandom);
                sel[k] = 4'($urandom);
                adr[k] = $urandom;
                dat[k] = $urandom;
            end
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(0, 3) != 0) || (starve >= 8);
            #1;
            exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0;
            exp_adr = 32'd0; exp_dat = 32'd0; exp_sel = 4'd0; exp_ack = 4'd0;
            if (mg >= 0) begin
                exp_cyc = cyc[mg]; exp_stb = stb[mg]; exp_we = we[mg];
                exp_adr = adr[mg]; exp_dat = dat[mg]; exp_sel = sel[mg];
                if (s_ack_i && stb[mg]) exp_ack[mg] = 1'b1;
            end
            tests++;
            if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !==
                {exp_cyc, exp_stb, exp_we, exp_sel, exp_adr, exp_dat}) begin
                fails++;
                $display("FAIL rand_slave[%0d]: cyc/stb/we=%b%b%b sel=%h adr=%h dat=%h, want %b%b%b %h %h %h",
                         n, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
                         exp_cyc, exp_stb, exp_we, exp_sel, exp_adr, exp_dat);
            end
            tests++;
            if (m_ack_o !== exp_ack || m_dat_o !== s_dat_i || m_err_o !== 4'b0) begin
                fails++;
                $display("FAIL rand_master[%0d]: ack=%b dat=%h err=%b, want %b %h 0000",
                         n, m_ack_o, m_dat_o, m_err_o, exp_ack, s_dat_i);
            end
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (exp_ack[k]) begin
                    beats[k]--;
                    if (beats[k] == 0) drop[k] = 1'b1;
                end
            end
            if (mg >= 0 && stb[mg] && !s_ack_i) starve++;
            else starve = 0;
            if (mg < 0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (cyc[(ml + i) % 4]) begin
                        mg = (ml + i) % 4;
                        break;
                    end
                end
            end else if (!cyc[mg]) begin
                ml = mg;
                mg = -1;
            end
            #1;
            exp_gnt = (mg >= 0) ? (4'b0001 << mg) : 4'b0000;
            tests++;
            if (gnt_o !== exp_gnt) begin
                fails++;
                $display("FAIL rand_gnt[%0d]: gnt=%b, want %b", n, gnt_o, exp_gnt);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_rotation();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
